// File: rtl/serial_alu_if.sv
// Handshake and operand/result bundle for the bit-serial ALU.
// The master issues operations; the slave (the ALU) returns registered results and flags.
interface serial_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;
  logic             illegal;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, ALUOp,
    input  result, zero, carry_out, overflow, illegal, busy, done
  );

  modport slave (
    input  start, a, b, ALUOp,
    output result, zero, carry_out, overflow, illegal, busy, done
  );
endinterface

// File: rtl/serial_alu.sv
// Bit-serial N-bit ALU: one result bit per clock, LSB first, carry threaded between cycles.
// Results and flags are published only on completion and held until the next completion.
//
// state  | meaning
// S_IDLE | waiting for start, outputs hold last completed result
// S_RUN  | shifting one bit per cycle, busy high
// S_DONE | one-cycle completion strobe; start here issues back-to-back
module serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_alu_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic [3:0]       op_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             cout_q;
  logic             ovf_q;
  logic             ill_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             last;
  logic             is_arith;
  logic             is_legal;
  logic             a0;
  logic             b0;
  logic             bit_d;
  logic             cout_d;
  logic [WIDTH-1:0] res_d;

  always_comb begin
    accept   = bus.start && (state_q == S_IDLE || state_q == S_DONE);
    last     = (cnt_q == CW'(WIDTH - 1));
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    is_legal = is_arith || (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_NOR);
    a0       = a_sh_q[0];
    b0       = b_sh_q[0];
    cout_d   = (a0 & b0) | (carry_q & (a0 ^ b0));
    bit_d    = 1'b0;
    case (op_q)
      OP_AND:         bit_d = a0 & b0;
      OP_OR:          bit_d = a0 | b0;
      OP_NOR:         bit_d = ~(a0 | b0);
      OP_ADD, OP_SUB: bit_d = a0 ^ b0 ^ carry_q;
      default:        bit_d = 1'b0;
    endcase
    res_d = {bit_d, res_sh_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            a_sh_q   <= bus.a;
            // Subtraction is A + ~B + 1: invert B once here and seed the carry with 1.
            b_sh_q   <= (bus.ALUOp == OP_SUB) ? ~bus.b : bus.b;
            carry_q  <= (bus.ALUOp == OP_SUB);
            op_q     <= bus.ALUOp;
            res_sh_q <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= res_d;
          carry_q  <= cout_d;
          if (last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (is_legal) begin
              result_q <= res_d;
              zero_q   <= (res_d == '0);
              cout_q   <= is_arith & cout_d;
              // carry_q still holds the carry into the MSB at this point
              ovf_q    <= is_arith & (carry_q ^ cout_d);
              ill_q    <= 1'b0;
            end else begin
              result_q <= '0;
              zero_q   <= 1'b1;
              cout_q   <= 1'b0;
              ovf_q    <= 1'b0;
              ill_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for the 8-bit serial ALU with hand-computed expected values.
module tb_serial_alu;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  serial_alu_if #(.WIDTH(W)) bus ();

  serial_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    bus.start = 1'b1;
    bus.ALUOp = op;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // n0 = edges already elapsed since the accepting edge
  task automatic wait_done(input string tag, input int n0);
    int  n;
    bit  seen;
    n    = n0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) seen = 1'b1;
    end
    chk({tag, " latency"}, 64'(n), 64'(W));
  endtask

  task automatic chk_out(input string tag, input logic [7:0] res, input logic z,
                         input logic c, input logic o, input logic ill);
    chk({tag, " result"},   64'(bus.result),    64'(res));
    chk({tag, " zero"},     64'(bus.zero),      64'(z));
    chk({tag, " carry"},    64'(bus.carry_out), 64'(c));
    chk({tag, " overflow"}, 64'(bus.overflow),  64'(o));
    chk({tag, " illegal"},  64'(bus.illegal),   64'(ill));
    chk({tag, " busy"},     64'(bus.busy),      64'(0));
  endtask

  initial begin
    int  seen_done;
    checks    = 0;
    passed    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.ALUOp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result", 64'(bus.result), 64'(0));
    chk("reset zero",   64'(bus.zero),   64'(0));
    chk("reset busy",   64'(bus.busy),   64'(0));
    chk("reset done",   64'(bus.done),   64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD with signed overflow
    issue(4'b0010, 8'h7F, 8'h01);
    chk("add busy", 64'(bus.busy), 64'(1));
    wait_done("add", 0);
    chk_out("add", 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("add done strobe", 64'(bus.done), 64'(0));

    issue(4'b0110, 8'h05, 8'h05);
    wait_done("sub eq", 0);
    chk_out("sub eq", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    issue(4'b0110, 8'h00, 8'h01);
    wait_done("sub borrow", 0);
    chk_out("sub borrow", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

    issue(4'b0000, 8'hF0, 8'h3C);
    wait_done("and", 0);
    chk_out("and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);

    issue(4'b0001, 8'hF0, 8'h3C);
    wait_done("or", 0);
    chk_out("or", 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0);

    issue(4'b1100, 8'hF0, 8'h3C);
    wait_done("nor", 0);
    chk_out("nor", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);

    // start re-pulsed during RUN must be ignored
    issue(4'b0010, 8'h12, 8'h34);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.ALUOp = 4'b0000;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("repulse busy", 64'(bus.busy), 64'(1));
    wait_done("repulse", 3);
    chk_out("repulse", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);

    // back-to-back: second op accepted on the edge where done is high
    issue(4'b0110, 8'h10, 8'h20);
    wait_done("b2b first", 0);
    chk_out("b2b first", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'b0010, 8'h80, 8'h80);
    chk("b2b busy", 64'(bus.busy), 64'(1));
    chk("b2b done drop", 64'(bus.done), 64'(0));
    chk("b2b hold result", 64'(bus.result), 64'(8'hF0));
    wait_done("b2b second", 0);
    chk_out("b2b second", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

    // reset in the third RUN cycle aborts the operation
    issue(4'b0010, 8'h7F, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort busy",     64'(bus.busy),      64'(0));
    chk("abort done",     64'(bus.done),      64'(0));
    chk("abort result",   64'(bus.result),    64'(0));
    chk("abort zero",     64'(bus.zero),      64'(0));
    chk("abort carry",    64'(bus.carry_out), 64'(0));
    chk("abort overflow", 64'(bus.overflow),  64'(0));
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen_done++;
    end
    chk("abort no done", 64'(seen_done), 64'(0));
    issue(4'b0010, 8'h01, 8'h02);
    wait_done("after abort", 0);
    chk_out("after abort", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);

    // unsupported opcode, then a legal op clears illegal
    issue(4'b0011, 8'h05, 8'h03);
    wait_done("illegal", 0);
    chk_out("illegal", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(4'b0010, 8'h01, 8'h01);
    wait_done("after illegal", 0);
    chk_out("after illegal", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
